reg_share_arbiter: RTL and testbench



---
 rtl/reg_share_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one clearable WIDTH-bit register among N_REQ writers.
// Grant one edge after req; writes commit per granted edge; tenure bounded by last/MAX_HOLD; sw_clear revokes.
module reg_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   sw_clear,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [IDX_W-1:0]       q_owner,
  output logic                   q_valid,
  output logic                   busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               valid_q, valid_d;
  logic [3:0]         hold_q, hold_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic [IDX_W-1:0]   win;
  logic               found;
  int                 idx;
  logic [3:0]         hold_inc;
  logic [WIDTH-1:0]   own_wdata;

  // Search starts just after the last winner so it ends up lowest priority.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  // While in GRANT, rr_q holds the current owner.
  assign own_wdata = wdata[int'(rr_q)*WIDTH +: WIDTH];
  assign hold_inc  = hold_q + 4'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    owner_d = owner_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (sw_clear) begin
          data_d  = '0;
          valid_d = 1'b0;
        end else if (found) begin
          gnt_d   = N_REQ'(1) << win;
          rr_d    = win;
          hold_d  = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (sw_clear) begin
          data_d  = '0;
          valid_d = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (!req[rr_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          data_d  = own_wdata;
          owner_d = rr_q;
          valid_d = 1'b1;
          hold_d  = hold_inc;
          if (last[rr_q] || (hold_inc == 4'(MAX_HOLD))) begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      hold_q  <= 4'd0;
      rr_q    <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_owner = owner_q;
  assign q_valid = valid_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench: stimulus pushes hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_reg_share_arbiter;

  logic        clk;
  logic        clear_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] wdata;
  logic        sw_clear;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        q_valid;
  logic        busy;

  logic [7:0]  wd [4];
  assign wdata = {wd[3], wd[2], wd[1], wd[0]};

  reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .clear_n(clear_n), .req(req), .last(last), .wdata(wdata),
    .sw_clear(sw_clear), .gnt(gnt), .q(q), .q_owner(q_owner),
    .q_valid(q_valid), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] q;
    logic       v;
    logic [1:0] o;
  } exp_t;

  exp_t exp_q [$];
  int   n_chk = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",     8'(gnt),     8'(e.g));
      chk("q",       q,           e.q);
      chk("q_valid", 8'(q_valid), 8'(e.v));
      chk("q_owner", 8'(q_owner), 8'(e.o));
      chk("busy",    8'(busy),    8'(|e.g));
    end
  end

  // Drive inputs, let one edge pass, record what the outputs must show after it.
  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic s,
                     input logic [3:0] eg, input logic [7:0] eq, input logic ev,
                     input logic [1:0] eo);
    exp_t e;
    req = r; last = l; sw_clear = s;
    @(posedge clk);
    e = {eg, eq, ev, eo};
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    logic [7:0] e_q;
    logic [1:0] e_o;
    logic [1:0] o;
    exp_t       z;
    clear_n = 1'b0; req = '0; last = '0; sw_clear = 1'b0;
    for (int i = 0; i < 4; i++) wd[i] = 8'h00;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) wd[j] = 8'($urandom);
      cyc(4'($urandom), 4'($urandom), 1'($urandom), 4'h0, 8'h00, 1'b0, 2'd0);
    end
    clear_n = 1'b1;
    for (int i = 0; i < 4; i++) wd[i] = 8'h00;

    // First grant goes to the lone requester 2, then it abandons without writing
    cyc(4'b0100, 4'b0000, 1'b0, 4'b0100, 8'h00, 1'b0, 2'd0);
    wd[2] = 8'h5A;
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);

    // Forced rotation: 3 holds req, 0 pending
    cyc(4'b1001, 4'b0000, 1'b0, 4'b1000, 8'h00, 1'b0, 2'd0);
    wd[3] = 8'h31; cyc(4'b1001, 4'b0000, 1'b0, 4'b1000, 8'h31, 1'b1, 2'd3);
    wd[3] = 8'h32; cyc(4'b1001, 4'b0000, 1'b0, 4'b1000, 8'h32, 1'b1, 2'd3);
    wd[3] = 8'h33; cyc(4'b1001, 4'b0000, 1'b0, 4'b1000, 8'h33, 1'b1, 2'd3);
    wd[3] = 8'h34; cyc(4'b1001, 4'b0000, 1'b0, 4'b0000, 8'h34, 1'b1, 2'd3);
    cyc(4'b1001, 4'b0000, 1'b0, 4'b0001, 8'h34, 1'b1, 2'd3);
    wd[0] = 8'h0A; cyc(4'b1001, 4'b0001, 1'b0, 4'b0000, 8'h0A, 1'b1, 2'd0);
    cyc(4'b1001, 4'b0000, 1'b0, 4'b1000, 8'h0A, 1'b1, 2'd0);
    wd[3] = 8'h3F; cyc(4'b1001, 4'b1000, 1'b0, 4'b0000, 8'h3F, 1'b1, 2'd3);

    // Fairness: all request continuously, tenures 0,1,2,3,0 of MAX_HOLD writes
    e_q = 8'h3F; e_o = 2'd3;
    for (int t = 0; t < 5; t++) begin
      o = 2'(t % 4);
      cyc(4'hF, 4'h0, 1'b0, 4'b0001 << o, e_q, 1'b1, e_o);
      for (int k = 1; k <= 4; k++) begin
        wd[o] = 8'(16 * o + k);
        e_q = wd[o]; e_o = o;
        cyc(4'hF, 4'h0, 1'b0, (k == 4) ? 4'h0 : (4'b0001 << o), e_q, 1'b1, e_o);
      end
    end

    // Single burst by requester 1 with last on the third write
    cyc(4'b0010, 4'b0000, 1'b0, 4'b0010, 8'h04, 1'b1, 2'd0);
    wd[1] = 8'h11; cyc(4'b0010, 4'b0000, 1'b0, 4'b0010, 8'h11, 1'b1, 2'd1);
    wd[1] = 8'h22; cyc(4'b0010, 4'b0000, 1'b0, 4'b0010, 8'h22, 1'b1, 2'd1);
    wd[1] = 8'h33; cyc(4'b0010, 4'b0010, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd1);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd1);

    // Clear colliding with a write, then clear in IDLE defers arbitration
    cyc(4'b0100, 4'b0000, 1'b0, 4'b0100, 8'h33, 1'b1, 2'd1);
    wd[2] = 8'hAA; cyc(4'b0100, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd1);
    cyc(4'b0100, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd1);
    cyc(4'b0100, 4'b0000, 1'b0, 4'b0100, 8'h00, 1'b0, 2'd1);

    // Abandon mid-tenure
    wd[2] = 8'h21; cyc(4'b0100, 4'b0000, 1'b0, 4'b0100, 8'h21, 1'b1, 2'd2);
    wd[2] = 8'h22; cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h21, 1'b1, 2'd2);
    cyc(4'b0100, 4'b0000, 1'b0, 4'b0100, 8'h21, 1'b1, 2'd2);

    // Async reset between edges during GRANT
    req = 4'b0100; wd[2] = 8'h23;
    @(posedge clk);
    #1;
    clear_n = 1'b0;
    z = '0;
    exp_q.push_back(z);
    @(negedge clk);
    #1;
    clear_n = 1'b1;
    // Pointer back at N_REQ-1, so requester 0 wins first
    cyc(4'b0001, 4'b0000, 1'b0, 4'b0001, 8'h00, 1'b0, 2'd0);
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
